// File: rtl/ex2_sad_best_tracker_pkg.sv
// Shared types and constants for the EX2 SAD best-candidate tracker.
// Optional feature macro used by the tracker files: SAD_TRACKER_PERF_EN.
package sad_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Index of the last-candidate flag within check_wcol_out_EX2
    localparam int unsigned LAST_BIT = 1;

    localparam int unsigned SAD_DATA_W = 32;
    localparam int unsigned SAD_CNT_W  = 16;

endpackage

// File: rtl/ex2_sad_best_tracker_if.sv
// Candidate/result bundle between the EX1/EX2 latch, the tracker and MEM/WB.
// SAD_TRACKER_PERF_EN adds the search_cycles performance counter output.
interface ex2_sad_best_tracker_if
    import sad_tracker_pkg::*;
#(
    parameter int unsigned DATA_W = SAD_DATA_W,
    parameter int unsigned CNT_W  = SAD_CNT_W
);
    logic              Stall;
    logic              Flush;
    logic              sad_EX2;
    logic [DATA_W-1:0] t1_sad_value_EX2;
    logic [DATA_W-1:0] outx_EX2;
    logic [DATA_W-1:0] outy_EX2;
    logic [1:0]        check_wcol_out_EX2;

    logic [DATA_W-1:0] best_sad;
    logic [DATA_W-1:0] best_x;
    logic [DATA_W-1:0] best_y;
    logic [CNT_W-1:0]  cand_count;
    logic              busy;
    logic              search_done;
    logic              overflow;
`ifdef SAD_TRACKER_PERF_EN
    logic [CNT_W-1:0]  search_cycles;

    modport master (
        output Stall, Flush, sad_EX2, t1_sad_value_EX2, outx_EX2, outy_EX2, check_wcol_out_EX2,
        input  best_sad, best_x, best_y, cand_count, busy, search_done, overflow, search_cycles
    );
    modport slave (
        input  Stall, Flush, sad_EX2, t1_sad_value_EX2, outx_EX2, outy_EX2, check_wcol_out_EX2,
        output best_sad, best_x, best_y, cand_count, busy, search_done, overflow, search_cycles
    );
`else
    modport master (
        output Stall, Flush, sad_EX2, t1_sad_value_EX2, outx_EX2, outy_EX2, check_wcol_out_EX2,
        input  best_sad, best_x, best_y, cand_count, busy, search_done, overflow
    );
    modport slave (
        input  Stall, Flush, sad_EX2, t1_sad_value_EX2, outx_EX2, outy_EX2, check_wcol_out_EX2,
        output best_sad, best_x, best_y, cand_count, busy, search_done, overflow
    );
`endif

endinterface

// File: rtl/ex2_sad_best_tracker_min_cmp.sv
// Combinational strictly-less comparator deciding whether a candidate replaces the best SAD.
module sad_min_cmp
    import sad_tracker_pkg::*;
#(
    parameter int unsigned DATA_W = SAD_DATA_W
) (
    input  logic [DATA_W-1:0] cand_sad_i,
    input  logic [DATA_W-1:0] best_sad_i,
    output logic              replace_o
);

    // Ties keep the earlier candidate
    assign replace_o = (cand_sad_i < best_sad_i);

endmodule

// File: rtl/ex2_sad_best_tracker.sv
// EX2 minimum-SAD tracker: keeps best SAD and coordinates across one motion-search sweep.
// SAD_TRACKER_PERF_EN enables the search_cycles counter; disabled by default.
module ex2_sad_best_tracker
    import sad_tracker_pkg::*;
#(
    parameter int unsigned DATA_W         = SAD_DATA_W,
    parameter int unsigned CNT_W          = SAD_CNT_W,
    parameter int unsigned MAX_CANDIDATES = 1024
) (
    input logic                  Clk,
    input logic                  Reset,
    ex2_sad_best_tracker_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CANDIDATES);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] best_sad_q, best_sad_d;
    logic [DATA_W-1:0] best_x_q, best_x_d;
    logic [DATA_W-1:0] best_y_q, best_y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              last;
    logic              replace;
    logic [CNT_W-1:0]  cnt_inc;
    logic              unused_wcol0;

    assign accept       = bus.sad_EX2 & ~bus.Stall & ~bus.Flush;
    assign last         = bus.check_wcol_out_EX2[LAST_BIT];
    assign unused_wcol0 = bus.check_wcol_out_EX2[0];
    assign cnt_inc      = cnt_q + 1'b1;

    sad_min_cmp #(.DATA_W(DATA_W)) u_cmp (
        .cand_sad_i (bus.t1_sad_value_EX2),
        .best_sad_i (best_sad_q),
        .replace_o  (replace)
    );

    always_comb begin
        state_d    = state_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (bus.Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        best_sad_d = bus.t1_sad_value_EX2;
                        best_x_d   = bus.outx_EX2;
                        best_y_d   = bus.outy_EX2;
                        cnt_d      = CNT_W'(1);
                        ovf_d      = 1'b0;
                        state_d    = last ? DONE : SEARCH;
                    end
                end
                SEARCH: begin
                    if (accept) begin
                        if (replace) begin
                            best_sad_d = bus.t1_sad_value_EX2;
                            best_x_d   = bus.outx_EX2;
                            best_y_d   = bus.outy_EX2;
                        end
                        cnt_d = cnt_inc;
                        // Overflow only flags forced termination, not a natural last candidate
                        if (last) begin
                            state_d = DONE;
                        end else if (cnt_inc == MAX_CNT) begin
                            state_d = DONE;
                            ovf_d   = 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            best_sad_q <= '1;
            best_x_q   <= '0;
            best_y_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.best_sad    = best_sad_q;
    assign bus.best_x      = best_x_q;
    assign bus.best_y      = best_y_q;
    assign bus.cand_count  = cnt_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = (state_q == SEARCH);
    assign bus.search_done = (state_q == DONE);

`ifdef SAD_TRACKER_PERF_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;

    // Counts every non-IDLE cycle, stalled or not, and holds after DONE until the next sweep
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE) begin
            if (state_d != IDLE) begin
                cyc_d = '0;
            end
        end else if (cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.search_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_ex2_sad_best_tracker.sv
// Self-checking bench for ex2_sad_best_tracker: directed table, corner sequences, random vs model.
module tb_ex2_sad_best_tracker;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    ex2_sad_best_tracker_if #(.DATA_W(32), .CNT_W(16)) bus_a ();
    ex2_sad_best_tracker_if #(.DATA_W(32), .CNT_W(16)) bus_b ();

    ex2_sad_best_tracker #(.DATA_W(32), .CNT_W(16), .MAX_CANDIDATES(1024)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a)
    );
    ex2_sad_best_tracker #(.DATA_W(32), .CNT_W(16), .MAX_CANDIDATES(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b)
    );

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    typedef struct {
        bit          stall, flush, strobe, last;
        logic [31:0] sad, x, y;
        logic [31:0] e_sad, e_x, e_y;
        logic [15:0] e_cnt;
        bit          e_busy, e_done, e_ovf;
    } vec_t;
    vec_t vecs[$];

    // Reference model: sweep-level flags rather than a state machine
    bit          m_active[2];
    bit          m_pulse[2];
    bit          m_ovf[2];
    logic [31:0] m_best[2], m_x[2], m_y[2];
    int unsigned m_cnt[2];
    int unsigned m_max[2];

    bit          d_stall, d_flush, d_strobe, d_last;
    logic [31:0] d_sad, d_x, d_y;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit st, input bit fl, input bit sb, input logic [31:0] sad,
                         input logic [31:0] x, input logic [31:0] y, input bit last);
        d_stall = st; d_flush = fl; d_strobe = sb; d_sad = sad; d_x = x; d_y = y; d_last = last;
        bus_a.Stall = st; bus_a.Flush = fl; bus_a.sad_EX2 = sb;
        bus_a.t1_sad_value_EX2 = sad; bus_a.outx_EX2 = x; bus_a.outy_EX2 = y;
        bus_a.check_wcol_out_EX2 = {last, 1'b1};
        bus_b.Stall = st; bus_b.Flush = fl; bus_b.sad_EX2 = sb;
        bus_b.t1_sad_value_EX2 = sad; bus_b.outx_EX2 = x; bus_b.outy_EX2 = y;
        bus_b.check_wcol_out_EX2 = {last, 1'b0};
    endtask

    task automatic get_out(input int d, output logic [31:0] s, output logic [31:0] x,
                           output logic [31:0] y, output logic [15:0] c,
                           output logic b, output logic dn, output logic o);
        if (d == 0) begin
            s = bus_a.best_sad; x = bus_a.best_x; y = bus_a.best_y; c = bus_a.cand_count;
            b = bus_a.busy; dn = bus_a.search_done; o = bus_a.overflow;
        end else begin
            s = bus_b.best_sad; x = bus_b.best_x; y = bus_b.best_y; c = bus_b.cand_count;
            b = bus_b.busy; dn = bus_b.search_done; o = bus_b.overflow;
        end
    endtask

    task automatic model_reset(input int d);
        m_active[d] = 0; m_pulse[d] = 0; m_ovf[d] = 0;
        m_best[d] = 32'hFFFF_FFFF; m_x[d] = '0; m_y[d] = '0; m_cnt[d] = 0;
    endtask

    task automatic model_step(input int d);
        if (d_flush) begin
            m_active[d] = 0; m_pulse[d] = 0; m_cnt[d] = 0;
        end else if (m_pulse[d]) begin
            m_pulse[d] = 0;
        end else if (!d_stall && d_strobe) begin
            if (!m_active[d]) begin
                m_best[d] = d_sad; m_x[d] = d_x; m_y[d] = d_y;
                m_cnt[d] = 1; m_ovf[d] = 0;
                if (d_last) m_pulse[d] = 1; else m_active[d] = 1;
            end else begin
                if (d_sad < m_best[d]) begin
                    m_best[d] = d_sad; m_x[d] = d_x; m_y[d] = d_y;
                end
                m_cnt[d]++;
                if (d_last) begin
                    m_active[d] = 0; m_pulse[d] = 1;
                end else if (m_cnt[d] == m_max[d]) begin
                    m_active[d] = 0; m_pulse[d] = 1; m_ovf[d] = 1;
                end
            end
        end
    endtask

    task automatic model_check(input int d);
        logic [31:0] s, x, y;
        logic [15:0] c;
        logic        b, dn, o;
        get_out(d, s, x, y, c, b, dn, o);
        chk($sformatf("model%0d.best_sad", d), s, m_best[d]);
        chk($sformatf("model%0d.best_x", d), x, m_x[d]);
        chk($sformatf("model%0d.best_y", d), y, m_y[d]);
        chk($sformatf("model%0d.cand_count", d), c, m_cnt[d]);
        chk($sformatf("model%0d.busy", d), b, m_active[d]);
        chk($sformatf("model%0d.search_done", d), dn, m_pulse[d]);
        chk($sformatf("model%0d.overflow", d), o, m_ovf[d]);
    endtask

    task automatic check_reset_values(input int d, input string tag);
        logic [31:0] s, x, y;
        logic [15:0] c;
        logic        b, dn, o;
        get_out(d, s, x, y, c, b, dn, o);
        chk({tag, ".best_sad"}, s, 32'hFFFF_FFFF);
        chk({tag, ".best_xy"}, {x, y}, 64'd0);
        chk({tag, ".cand_count"}, c, 16'd0);
        chk({tag, ".busy_done_ovf"}, {b, dn, o}, 3'b000);
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step(0);
        model_step(1);
        @(negedge Clk);
        model_check(0);
        model_check(1);
    endtask

    task automatic add(input bit st, input bit fl, input bit sb, input logic [31:0] sad,
                       input logic [31:0] x, input logic [31:0] y, input bit last,
                       input logic [31:0] es, input logic [31:0] ex, input logic [31:0] ey,
                       input logic [15:0] ec, input bit eb, input bit ed, input bit eo);
        vec_t v;
        v.stall = st; v.flush = fl; v.strobe = sb; v.sad = sad; v.x = x; v.y = y; v.last = last;
        v.e_sad = es; v.e_x = ex; v.e_y = ey; v.e_cnt = ec;
        v.e_busy = eb; v.e_done = ed; v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    initial begin
        m_max[0] = 1024;
        m_max[1] = 4;
        model_reset(0);
        model_reset(1);

        //  st fl sb sad           x   y   last | best          x   y   cnt busy done ovf
        add(0, 0, 1, 50,           3,  4,  1,     50,           3,  4,  1,  0,   1,   0);
        add(0, 0, 0, 0,            0,  0,  0,     50,           3,  4,  1,  0,   0,   0);
        add(0, 0, 1, 90,           0,  0,  0,     90,           0,  0,  1,  1,   0,   0);
        add(0, 0, 1, 40,           1,  11, 0,     40,           1,  11, 2,  1,   0,   0);
        add(0, 0, 1, 40,           2,  12, 0,     40,           1,  11, 3,  1,   0,   0);
        add(0, 0, 1, 70,           3,  13, 1,     40,           1,  11, 4,  0,   1,   0);
        add(0, 0, 0, 0,            0,  0,  0,     40,           1,  11, 4,  0,   0,   0);
        add(0, 0, 1, 80,           7,  7,  0,     80,           7,  7,  1,  1,   0,   0);
        add(1, 0, 1, 5,            9,  9,  1,     80,           7,  7,  1,  1,   0,   0);
        add(1, 0, 1, 5,            9,  9,  1,     80,           7,  7,  1,  1,   0,   0);
        add(1, 0, 1, 5,            9,  9,  1,     80,           7,  7,  1,  1,   0,   0);
        add(0, 0, 1, 5,            9,  9,  1,     5,            9,  9,  2,  0,   1,   0);
        add(0, 0, 0, 0,            0,  0,  0,     5,            9,  9,  2,  0,   0,   0);
        add(0, 0, 1, 60,           1,  1,  0,     60,           1,  1,  1,  1,   0,   0);
        add(0, 0, 1, 30,           2,  2,  0,     30,           2,  2,  2,  1,   0,   0);
        add(0, 1, 1, 10,           3,  3,  1,     30,           2,  2,  0,  0,   0,   0);
        add(0, 0, 0, 0,            0,  0,  0,     30,           2,  2,  0,  0,   0,   0);
        add(0, 0, 1, 20,           5,  5,  1,     20,           5,  5,  1,  0,   1,   0);
        add(0, 0, 1, 1,            6,  6,  1,     20,           5,  5,  1,  0,   0,   0);
        add(0, 0, 0, 0,            0,  0,  0,     20,           5,  5,  1,  0,   0,   0);
        add(0, 0, 1, 32'hFFFFFFFE, 8,  8,  0,     32'hFFFFFFFE, 8,  8,  1,  1,   0,   0);
        add(0, 0, 1, 32'hFFFFFFFF, 9,  9,  0,     32'hFFFFFFFE, 8,  8,  2,  1,   0,   0);
        add(0, 0, 1, 0,            10, 10, 1,     0,            10, 10, 3,  0,   1,   0);
        add(1, 0, 0, 0,            0,  0,  0,     0,            10, 10, 3,  0,   0,   0);

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        check_reset_values(0, "por_a");
        check_reset_values(1, "por_b");
        Reset = 1'b1;

        foreach (vecs[i]) begin
            logic [31:0] s, x, y;
            logic [15:0] c;
            logic        b, dn, o;
            drive(vecs[i].stall, vecs[i].flush, vecs[i].strobe, vecs[i].sad,
                  vecs[i].x, vecs[i].y, vecs[i].last);
            cycle();
            get_out(0, s, x, y, c, b, dn, o);
            chk($sformatf("vec%0d.best", i), {s, x}, {vecs[i].e_sad, vecs[i].e_x});
            chk($sformatf("vec%0d.best_y", i), y, vecs[i].e_y);
            chk($sformatf("vec%0d.cand_count", i), c, vecs[i].e_cnt);
            chk($sformatf("vec%0d.busy_done_ovf", i), {b, dn, o},
                {vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ovf});
        end

        // Forced termination on the MAX_CANDIDATES=4 instance
        for (int unsigned k = 0; k < 4; k++) begin
            drive(0, 0, 1, 100 - k, k, k + 20, 0);
            cycle();
        end
        chk("ovf_b.flags", {bus_b.busy, bus_b.search_done, bus_b.overflow}, 3'b011);
        chk("ovf_b.cand_count", bus_b.cand_count, 16'd4);
        chk("ovf_b.best", {bus_b.best_sad, bus_b.best_x}, {32'd97, 32'd3});
        chk("ovf_a.still_busy", {bus_a.busy, bus_a.overflow}, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("ovf_b.held", {bus_b.search_done, bus_b.overflow}, 2'b01);
        drive(0, 1, 0, 0, 0, 0, 0);
        cycle();

        // Asynchronous reset in the middle of a sweep
        drive(0, 0, 1, 77, 1, 2, 0);
        cycle();
        drive(0, 0, 1, 66, 3, 4, 0);
        cycle();
        #2 Reset = 1'b0;
        #1;
        check_reset_values(0, "areset_a");
        check_reset_values(1, "areset_b");
        model_reset(0);
        model_reset(1);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        cycle();
        drive(0, 0, 1, 12, 5, 6, 1);
        cycle();
        chk("post_reset.best", {bus_a.best_sad, bus_a.search_done}, {32'd12, 1'b1});

        for (int unsigned n = 0; n < 4000; n++) begin
            logic [31:0] sad;
            sad = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, sad, $urandom, $urandom,
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset = 1'b0;
                #1;
                model_reset(0);
                model_reset(1);
                model_check(0);
                model_check(1);
                @(negedge Clk);
                Reset = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
